// File: rtl/unidade_escrita_banco_pkg.sv
// Shared types and constants for the register-bank write-back path.
package pkg_escrita;

    typedef struct packed {
        logic [4:0]  idx;
        logic [31:0] dado;
    } entrada_escrita_t;

    localparam int FONTE_JUMP    = 0;
    localparam int FONTE_MEM     = 1;
    localparam int FONTE_ULA     = 2;
    localparam int FONTE_DADO    = 3;
    localparam int NUM_FONTES    = 4;
    localparam int REG_ESCRITA_W = 9;

endpackage

// File: rtl/unidade_escrita_banco_fila.sv
// Generic in-order FIFO; exposes every slot plus a per-slot occupancy mask
// so the owner can decode what is still in flight.
module fila_escrita
    import pkg_escrita::*;
#(
    parameter int PROFUNDIDADE = 4,
    parameter int LARGURA      = 37
)
(
    input  logic                                       clock,
    input  logic                                       reset,
    input  logic                                       push,
    input  logic                                       pop,
    input  logic [LARGURA-1:0]                         entrada,
    output logic [LARGURA-1:0]                         cabeca,
    output logic                                       vazia,
    output logic [$clog2(PROFUNDIDADE):0]              contagem,
    output logic [PROFUNDIDADE-1:0][LARGURA-1:0]       entradas,
    output logic [PROFUNDIDADE-1:0]                    validas
);

    localparam int PW = $clog2(PROFUNDIDADE);

    logic [PW-1:0] cabeca_ptr;
    logic [PW-1:0] cauda_ptr;
    logic          cheia;
    logic          push_ok;
    logic          pop_ok;

    assign cheia   = (contagem == (PW+1)'(PROFUNDIDADE));
    assign vazia   = (contagem == '0);
    assign push_ok = push & ~cheia;
    assign pop_ok  = pop & ~vazia;
    assign cabeca  = entradas[cabeca_ptr];

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cabeca_ptr <= '0;
            cauda_ptr  <= '0;
            contagem   <= '0;
            entradas   <= '0;
        end else begin
            if (push_ok) begin
                entradas[cauda_ptr] <= entrada;
                cauda_ptr           <= cauda_ptr + 1'b1;
            end
            if (pop_ok) begin
                cabeca_ptr <= cabeca_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   contagem <= contagem + 1'b1;
                2'b01:   contagem <= contagem - 1'b1;
                default: ;
            endcase
        end
    end

    // A slot is live when its distance from the head is below the occupancy.
    always_comb begin
        validas = '0;
        for (int i = 0; i < PROFUNDIDADE; i++) begin
            validas[i] = ({1'b0, PW'(i) - cabeca_ptr} < contagem);
        end
    end

endmodule

// File: rtl/unidade_escrita_banco.sv
// Write-back sequencer: fixed-priority arbitration of four producers into an
// in-order queue drained through the bank's single write port.
module unidade_escrita_banco
    import pkg_escrita::*;
#(
    parameter int PROFUNDIDADE = 4,
    parameter int LARGURA      = 32
)
(
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     ValidoJump,
    input  logic                     ValidoMem,
    input  logic                     ValidoULA,
    input  logic                     ValidoDado,
    input  logic [4:0]               RegJump,
    input  logic [4:0]               RegMem,
    input  logic [4:0]               RegULA,
    input  logic [4:0]               RegDado,
    input  logic [LARGURA-1:0]       EnderecoPC,
    input  logic [LARGURA-1:0]       Memoria,
    input  logic [LARGURA-1:0]       EscritaULA,
    input  logic [LARGURA-1:0]       DadoImediato,
    output logic                     ProntoJump,
    output logic                     ProntoMem,
    output logic                     ProntoULA,
    output logic                     ProntoDado,
    input  logic                     Bloqueio,
    output logic                     FlagEscrita,
    output logic [REG_ESCRITA_W-1:0] RegEscrita,
    output logic [LARGURA-1:0]       DadoEscrita,
    output logic [31:0]              Pendente,
    output logic                     Cheia,
    output logic                     Vazia
);

    localparam int LE = 5 + LARGURA;
    localparam int CW = $clog2(PROFUNDIDADE) + 1;

    logic [NUM_FONTES-1:0]               concessao;
    logic [LE-1:0]                       entrada_nova;
    logic [LE-1:0]                       cabeca;
    logic [CW-1:0]                       contagem;
    logic [PROFUNDIDADE-1:0][LE-1:0]     entradas;
    logic [PROFUNDIDADE-1:0]             validas;
    logic                                vazia;

    // Grant depends only on the current occupancy: no look-ahead on a pop.
    always_comb begin
        concessao = '0;
        if (!Cheia) begin
            if (ValidoJump)      concessao[FONTE_JUMP] = 1'b1;
            else if (ValidoMem)  concessao[FONTE_MEM]  = 1'b1;
            else if (ValidoULA)  concessao[FONTE_ULA]  = 1'b1;
            else if (ValidoDado) concessao[FONTE_DADO] = 1'b1;
        end
    end

    always_comb begin
        entrada_nova = '0;
        if (concessao[FONTE_JUMP])      entrada_nova = {RegJump, EnderecoPC};
        else if (concessao[FONTE_MEM])  entrada_nova = {RegMem, Memoria};
        else if (concessao[FONTE_ULA])  entrada_nova = {RegULA, EscritaULA};
        else if (concessao[FONTE_DADO]) entrada_nova = {RegDado, DadoImediato};
    end

    assign ProntoJump = concessao[FONTE_JUMP];
    assign ProntoMem  = concessao[FONTE_MEM];
    assign ProntoULA  = concessao[FONTE_ULA];
    assign ProntoDado = concessao[FONTE_DADO];

    fila_escrita #(
        .PROFUNDIDADE (PROFUNDIDADE),
        .LARGURA      (LE)
    ) u_fila (
        .clock    (clock),
        .reset    (reset),
        .push     (|concessao),
        .pop      (FlagEscrita),
        .entrada  (entrada_nova),
        .cabeca   (cabeca),
        .vazia    (vazia),
        .contagem (contagem),
        .entradas (entradas),
        .validas  (validas)
    );

    assign Vazia       = vazia;
    assign Cheia       = (contagem == CW'(PROFUNDIDADE));
    assign FlagEscrita = ~vazia & ~Bloqueio;

    // Stale slot contents are hidden so an empty queue presents all zeros.
    assign RegEscrita  = vazia ? '0 : {4'b0, cabeca[LE-1 -: 5]};
    assign DadoEscrita = vazia ? '0 : cabeca[LARGURA-1:0];

    always_comb begin
        Pendente = '0;
        for (int i = 0; i < PROFUNDIDADE; i++) begin
            if (validas[i]) Pendente[entradas[i][LE-1 -: 5]] = 1'b1;
        end
    end

endmodule

// File: tb/tb_unidade_escrita_banco.sv
// Self-checking bench: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_unidade_escrita_banco;

    localparam int PROF = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ValidoJump = 0, ValidoMem = 0, ValidoULA = 0, ValidoDado = 0;
    logic [4:0]  RegJump = 0, RegMem = 0, RegULA = 0, RegDado = 0;
    logic [31:0] EnderecoPC = 0, Memoria = 0, EscritaULA = 0, DadoImediato = 0;
    logic        ProntoJump, ProntoMem, ProntoULA, ProntoDado;
    logic        Bloqueio = 0;
    logic        FlagEscrita;
    logic [8:0]  RegEscrita;
    logic [31:0] DadoEscrita;
    logic [31:0] Pendente;
    logic        Cheia, Vazia;

    int n_comparados  = 0;
    int n_divergentes = 0;
    int dut_aceites   = 0;
    int dut_escritas  = 0;
    logic reset_visto = 1'b0;
    logic [36:0] fila_modelo[$];

    unidade_escrita_banco #(.PROFUNDIDADE(PROF), .LARGURA(32)) dut (
        .clock(clock), .reset(reset),
        .ValidoJump(ValidoJump), .ValidoMem(ValidoMem), .ValidoULA(ValidoULA), .ValidoDado(ValidoDado),
        .RegJump(RegJump), .RegMem(RegMem), .RegULA(RegULA), .RegDado(RegDado),
        .EnderecoPC(EnderecoPC), .Memoria(Memoria), .EscritaULA(EscritaULA), .DadoImediato(DadoImediato),
        .ProntoJump(ProntoJump), .ProntoMem(ProntoMem), .ProntoULA(ProntoULA), .ProntoDado(ProntoDado),
        .Bloqueio(Bloqueio), .FlagEscrita(FlagEscrita), .RegEscrita(RegEscrita),
        .DadoEscrita(DadoEscrita), .Pendente(Pendente), .Cheia(Cheia), .Vazia(Vazia)
    );

    always #5 clock = ~clock;

    always @(posedge reset) reset_visto = 1'b1;

    task automatic check_output(input string nome, input logic [63:0] atual, input logic [63:0] esperado);
        n_comparados++;
        if (atual !== esperado) begin
            n_divergentes++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", nome, atual, esperado, $time);
        end
    endtask

    task automatic proximo_ciclo();
        @(posedge clock);
        #1;
    endtask

    task automatic drena(input int limite);
        int k;
        k = 0;
        @(negedge clock);
        while (!Vazia && k < limite) begin
            proximo_ciclo();
            @(negedge clock);
            k++;
        end
        check_output("drain_bound", Vazia, 1'b1);
        proximo_ciclo();
    endtask

    // Reference model: a plain queue of {idx, data}; outputs derived from its contents.
    initial begin : comparador
        logic [3:0]  validos_m, pronto_m, pronto_dut;
        logic [36:0] cabeca_m, nova_m;
        logic [31:0] pend_m;
        logic        flag_m;
        forever begin
            @(negedge clock);
            if (reset || reset_visto) begin
                fila_modelo.delete();
                reset_visto = 1'b0;
            end
            validos_m = {ValidoDado, ValidoULA, ValidoMem, ValidoJump};
            pronto_m  = 4'b0000;
            nova_m    = '0;
            if (fila_modelo.size() < PROF) begin
                if (ValidoJump)      begin pronto_m = 4'b0001; nova_m = {RegJump, EnderecoPC};   end
                else if (ValidoMem)  begin pronto_m = 4'b0010; nova_m = {RegMem, Memoria};       end
                else if (ValidoULA)  begin pronto_m = 4'b0100; nova_m = {RegULA, EscritaULA};    end
                else if (ValidoDado) begin pronto_m = 4'b1000; nova_m = {RegDado, DadoImediato}; end
            end
            cabeca_m = (fila_modelo.size() != 0) ? fila_modelo[0] : 37'd0;
            flag_m   = (fila_modelo.size() != 0) && !Bloqueio;
            pend_m   = '0;
            foreach (fila_modelo[i]) pend_m[fila_modelo[i][36:32]] = 1'b1;
            pronto_dut = {ProntoDado, ProntoULA, ProntoMem, ProntoJump};

            check_output("pronto", pronto_dut, pronto_m);
            check_output("flag", FlagEscrita, flag_m);
            check_output("reg_escrita", RegEscrita, {4'b0, cabeca_m[36:32]});
            check_output("dado_escrita", DadoEscrita, cabeca_m[31:0]);
            check_output("pendente", Pendente, pend_m);
            check_output("cheia", Cheia, fila_modelo.size() == PROF);
            check_output("vazia", Vazia, fila_modelo.size() == 0);

            if (|(pronto_dut & validos_m)) dut_aceites++;
            if (FlagEscrita) dut_escritas++;

            @(posedge clock);
            if (!reset) begin
                if (flag_m) void'(fila_modelo.pop_front());
                if (|pronto_m) fila_modelo.push_back(nova_m);
            end
        end
    end

    initial begin : estimulo
        logic [31:0] anterior;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        @(negedge clock);
        check_output("reset_vazia", Vazia, 1'b1);
        check_output("reset_flag", FlagEscrita, 1'b0);
        check_output("reset_pendente", Pendente, 32'h0);
        proximo_ciclo();

        // Priority: all four at once, then each lower one in turn.
        ValidoJump = 1; RegJump = 5'd1; EnderecoPC   = 32'h101;
        ValidoMem  = 1; RegMem  = 5'd2; Memoria      = 32'h102;
        ValidoULA  = 1; RegULA  = 5'd3; EscritaULA   = 32'h103;
        ValidoDado = 1; RegDado = 5'd4; DadoImediato = 32'h104;
        @(negedge clock);
        check_output("prio_jump", {ProntoDado, ProntoULA, ProntoMem, ProntoJump}, 4'b0001);
        proximo_ciclo(); ValidoJump = 0;
        @(negedge clock);
        check_output("prio_reg1", RegEscrita, 9'd1);
        check_output("prio_mem", {ProntoDado, ProntoULA, ProntoMem, ProntoJump}, 4'b0010);
        proximo_ciclo(); ValidoMem = 0;
        @(negedge clock);
        check_output("prio_reg2", RegEscrita, 9'd2);
        check_output("prio_ula", {ProntoDado, ProntoULA, ProntoMem, ProntoJump}, 4'b0100);
        proximo_ciclo(); ValidoULA = 0;
        @(negedge clock);
        check_output("prio_reg3", RegEscrita, 9'd3);
        check_output("prio_dado", {ProntoDado, ProntoULA, ProntoMem, ProntoJump}, 4'b1000);
        proximo_ciclo(); ValidoDado = 0;
        @(negedge clock);
        check_output("prio_reg4", RegEscrita, 9'd4);
        check_output("prio_flag4", FlagEscrita, 1'b1);
        proximo_ciclo();
        drena(10);

        // Full with stall: regs 5..8 fill the queue, reg 9 waits.
        Bloqueio = 1;
        ValidoULA = 1; RegULA = 5'd5; EscritaULA = 32'h500;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            check_output("full_accept", ProntoULA, 1'b1);
            proximo_ciclo();
            RegULA = 5'(6 + k); EscritaULA = 32'h500 + 32'(k + 1);
        end
        @(negedge clock);
        check_output("full_cheia", Cheia, 1'b1);
        check_output("full_pronto", ProntoULA, 1'b0);
        check_output("full_pendente", Pendente, 32'h000001E0);
        check_output("full_flag", FlagEscrita, 1'b0);
        proximo_ciclo(); Bloqueio = 0;
        @(negedge clock);
        check_output("release_reg5", RegEscrita, 9'd5);
        check_output("release_pronto", ProntoULA, 1'b0);
        proximo_ciclo();
        @(negedge clock);
        check_output("release_reg6", RegEscrita, 9'd6);
        check_output("release_accept9", ProntoULA, 1'b1);
        proximo_ciclo(); ValidoULA = 0;
        drena(10);

        // Two writes to the same register keep their order.
        ValidoMem = 1; RegMem = 5'd7; Memoria = 32'hAAAA;
        @(negedge clock);
        check_output("same_mem_pronto", ProntoMem, 1'b1);
        proximo_ciclo(); ValidoMem = 0;
        ValidoULA = 1; RegULA = 5'd7; EscritaULA = 32'h5555;
        @(negedge clock);
        check_output("same_first", DadoEscrita, 32'hAAAA);
        check_output("same_pend_a", Pendente[7], 1'b1);
        proximo_ciclo(); ValidoULA = 0;
        @(negedge clock);
        check_output("same_second", DadoEscrita, 32'h5555);
        check_output("same_pend_b", Pendente[7], 1'b1);
        proximo_ciclo();
        @(negedge clock);
        check_output("same_pend_clear", Pendente[7], 1'b0);
        proximo_ciclo();

        // Steady stream: one push and one pop every cycle.
        anterior = '0;
        ValidoDado = 1;
        for (int k = 0; k < 8; k++) begin
            RegDado = 5'($urandom_range(0, 31)); DadoImediato = $urandom;
            @(negedge clock);
            if (k > 0) begin
                check_output("stream_dado", DadoEscrita, anterior);
                check_output("stream_flag", FlagEscrita, 1'b1);
            end
            anterior = DadoImediato;
            proximo_ciclo();
        end
        ValidoDado = 0;
        drena(10);

        // Asynchronous reset with three writes held behind the stall.
        Bloqueio = 1; ValidoJump = 1;
        for (int k = 0; k < 3; k++) begin
            RegJump = 5'(10 + k); EnderecoPC = 32'hC00 + 32'(k);
            proximo_ciclo();
        end
        ValidoJump = 0;
        check_output("pre_reset_pend", Pendente, 32'h00001C00);
        #1 reset = 1'b1;
        #1;
        check_output("rst_flag", FlagEscrita, 1'b0);
        check_output("rst_pend", Pendente, 32'h0);
        check_output("rst_reg", RegEscrita, 9'd0);
        check_output("rst_dado", DadoEscrita, 32'h0);
        check_output("rst_vazia", Vazia, 1'b1);
        #1 reset = 1'b0;
        dut_aceites = 0; dut_escritas = 0;
        Bloqueio = 0;

        // Randomized traffic with intermittent stalls and wrap-around.
        for (int k = 0; k < 300; k++) begin
            ValidoJump = 1'($urandom_range(0, 1)); RegJump = 5'($urandom_range(0, 31)); EnderecoPC   = $urandom;
            ValidoMem  = 1'($urandom_range(0, 1)); RegMem  = 5'($urandom_range(0, 31)); Memoria      = $urandom;
            ValidoULA  = 1'($urandom_range(0, 1)); RegULA  = 5'($urandom_range(0, 31)); EscritaULA   = $urandom;
            ValidoDado = 1'($urandom_range(0, 1)); RegDado = 5'($urandom_range(0, 31)); DadoImediato = $urandom;
            Bloqueio   = ($urandom_range(0, 3) == 0);
            proximo_ciclo();
        end
        ValidoJump = 0; ValidoMem = 0; ValidoULA = 0; ValidoDado = 0; Bloqueio = 0;
        drena(20);
        @(negedge clock);
        check_output("no_loss", 64'(dut_escritas), 64'(dut_aceites));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_comparados, n_divergentes);
        $finish;
    end

endmodule
